// File: rtl/jtkcpu_stack_seq_if.sv
// Memory-side bus of the stack sequencer: byte address, write data and
// strobe going out, read data and the memory stall coming back.
interface jtkcpu_stack_seq_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [7:0]  din;
  logic        mem_busy;

  // The sequencer drives the access, the memory answers it.
  modport master (output addr, dout, we, input din, mem_busy);
  modport slave  (input addr, dout, we, output din, mem_busy);
endinterface

// File: rtl/jtkcpu_stack_seq.sv
// Push/pull sequencer: turns one ucode push/pull strobe into a run of
// byte-wide stack accesses, stalling the ucode through stack_busy, and hands
// pulled registers back as load strobes plus one final stack-pointer update.
// The first byte is already on the bus in the start cycle, so a transfer
// occupies bytes+1 cycles (the extra one is DONE) plus any memory stalls.
module jtkcpu_stack_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        psh_go,
  input  logic        pul_go,
  input  logic        psh_all,
  input  logic        psh_cc,
  input  logic        psh_pc,
  input  logic        rti_cc,
  input  logic        rti_other,
  input  logic        us_sel,
  input  logic [7:0]  postbyte,
  input  logic [15:0] sp_in,
  input  logic [15:0] pc,
  input  logic [15:0] osp,
  input  logic [15:0] y,
  input  logic [15:0] x,
  input  logic [7:0]  dp,
  input  logic [7:0]  b,
  input  logic [7:0]  a,
  input  logic [7:0]  cc,
  jtkcpu_stack_seq_if.master mem,
  output logic        stack_busy,
  output logic        pul_we,
  output logic [2:0]  pul_sel,
  output logic [15:0] pul_data,
  output logic        sp_upd,
  output logic [15:0] sp_nx
);

  typedef enum logic [1:0] {IDLE, XFER_HI, XFER_LO, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  mask_reg;
  logic        push_reg;
  logic [15:0] sp_reg;
  logic [7:0]  hi_reg;
  logic        pul_we_reg;
  logic [2:0]  pul_sel_reg;
  logic [15:0] pul_data_reg;

  // us_sel only tells the ucode which SP receives sp_nx; the byte
  // sequencing is identical for both stacks.
  logic unused_sel;
  assign unused_sel = us_sel;

  // Highest set bit: pushes walk the mask from PC down to CC.
  function automatic logic [2:0] top_bit(input logic [7:0] m);
    top_bit = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) top_bit = i[2:0];
  endfunction

  // Lowest set bit: pulls walk the mask from CC up to PC.
  function automatic logic [2:0] bot_bit(input logic [7:0] m);
    bot_bit = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) bot_bit = i[2:0];
  endfunction

  logic        any_push, any_pull;
  logic [7:0]  new_mask;
  logic        start;
  logic        xfer;
  logic        adv;
  logic [7:0]  eff_mask;
  logic        eff_push;
  logic [15:0] eff_sp;
  logic [2:0]  cur_idx;
  logic        wide;
  logic        cur_hi;
  logic        reg_last;
  logic [7:0]  mask_left;
  logic [2:0]  nxt_idx;
  logic [15:0] sp_step;
  logic [15:0] cur_val;
  state_t      cur_state, next_first;

  // Mask selection: forced masks beat the postbyte, and any push source
  // beats any pull source.
  always_comb begin
    any_push = psh_all | psh_cc | psh_pc | psh_go;
    any_pull = rti_cc | rti_other | pul_go;
    new_mask = 8'h00;
    if (psh_all)        new_mask = 8'hFF;
    else if (psh_cc)    new_mask = 8'h81;
    else if (psh_pc)    new_mask = 8'h80;
    else if (psh_go)    new_mask = postbyte;
    else if (rti_cc)    new_mask = 8'h01;
    else if (rti_other) new_mask = 8'hFE;
    else if (pul_go)    new_mask = postbyte;
  end

  // In the start cycle the access runs straight from the inputs; afterwards
  // it runs from the latched copies. An empty mask never starts.
  assign start    = (state_reg == IDLE) && cen && (any_push || any_pull) && (new_mask != 8'h00);
  assign xfer     = start || (state_reg == XFER_HI) || (state_reg == XFER_LO);
  assign adv      = xfer && !mem.mem_busy;
  assign eff_mask = start ? new_mask : mask_reg;
  assign eff_push = start ? any_push : push_reg;
  assign eff_sp   = start ? sp_in : sp_reg;

  assign cur_idx   = eff_push ? top_bit(eff_mask) : bot_bit(eff_mask);
  assign wide      = cur_idx[2];
  // Pushes start a wide register on its low byte, pulls on its high byte.
  assign cur_hi    = start ? (!any_push && wide) : (state_reg == XFER_HI);
  assign cur_state = cur_hi ? XFER_HI : XFER_LO;
  assign reg_last  = eff_push ? (cur_hi || !wide) : !cur_hi;
  assign mask_left = eff_mask & ~(8'd1 << cur_idx);
  assign nxt_idx   = eff_push ? top_bit(mask_left) : bot_bit(mask_left);
  assign next_first = (!eff_push && nxt_idx[2]) ? XFER_HI : XFER_LO;
  assign sp_step   = eff_push ? (eff_sp - 16'd1) : (eff_sp + 16'd1);

  // Register file view in postbyte bit order; 8-bit registers zero-extended.
  always_comb begin
    case (cur_idx)
      3'd7:    cur_val = pc;
      3'd6:    cur_val = osp;
      3'd5:    cur_val = y;
      3'd4:    cur_val = x;
      3'd3:    cur_val = {8'h00, dp};
      3'd2:    cur_val = {8'h00, b};
      3'd1:    cur_val = {8'h00, a};
      default: cur_val = {8'h00, cc};
    endcase
  end

  // State register; reset drops any transfer in flight on the spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and bus/strobe outputs.
  always_comb begin
    state_next = state_reg;
    stack_busy = start || (state_reg != IDLE);
    mem.addr   = 16'h0000;
    mem.dout   = 8'h00;
    mem.we     = 1'b0;
    sp_upd     = 1'b0;
    sp_nx      = 16'h0000;
    case (state_reg)
      IDLE, XFER_HI, XFER_LO: begin
        if (xfer) begin
          mem.addr = eff_push ? (eff_sp - 16'd1) : eff_sp;
          mem.dout = eff_push ? (cur_hi ? cur_val[15:8] : cur_val[7:0]) : 8'h00;
          mem.we   = eff_push;
          if (cen) begin
            if (mem.mem_busy)            state_next = cur_state;
            else if (!reg_last)          state_next = eff_push ? XFER_HI : XFER_LO;
            else if (mask_left == 8'h00) state_next = DONE;
            else                         state_next = next_first;
          end
        end
      end
      DONE: begin
        sp_upd = 1'b1;
        sp_nx  = sp_reg;
        if (cen) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: remaining mask, running SP, pulled bytes and the load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg     <= 8'h00;
      push_reg     <= 1'b0;
      sp_reg       <= 16'h0000;
      hi_reg       <= 8'h00;
      pul_we_reg   <= 1'b0;
      pul_sel_reg  <= 3'd0;
      pul_data_reg <= 16'h0000;
    end else if (cen) begin
      pul_we_reg <= 1'b0;
      if (xfer) begin
        push_reg <= eff_push;
        mask_reg <= (adv && reg_last) ? mask_left : eff_mask;
        sp_reg   <= adv ? sp_step : eff_sp;
        if (adv && !eff_push) begin
          if (cur_hi) hi_reg <= mem.din;
          if (reg_last) begin
            pul_we_reg   <= 1'b1;
            pul_sel_reg  <= cur_idx;
            pul_data_reg <= {(wide ? hi_reg : 8'h00), mem.din};
          end
        end
      end
    end
  end

  assign pul_we   = pul_we_reg;
  assign pul_sel  = pul_sel_reg;
  assign pul_data = pul_data_reg;

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Bench for the stack sequencer: directed scenarios plus random operations,
// checked against a byte-list model of push/pull built from the register
// ordering and SP arithmetic rules.
module tb_jtkcpu_stack_seq;
  logic        clk = 1'b0;
  logic        rst, cen;
  logic        psh_go, pul_go, psh_all, psh_cc, psh_pc, rti_cc, rti_other, us_sel;
  logic [7:0]  postbyte, dp, b, a, cc;
  logic [15:0] sp_in, pc, osp, y, x;
  logic        stack_busy, pul_we, sp_upd;
  logic [2:0]  pul_sel;
  logic [15:0] pul_data, sp_nx;

  jtkcpu_stack_seq_if bus();

  logic [7:0] mem_arr [0:65535];
  logic [7:0] ref_mem [0:65535];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus.din = mem_arr[bus.addr];

  jtkcpu_stack_seq dut (
    .clk(clk), .rst(rst), .cen(cen),
    .psh_go(psh_go), .pul_go(pul_go), .psh_all(psh_all), .psh_cc(psh_cc),
    .psh_pc(psh_pc), .rti_cc(rti_cc), .rti_other(rti_other), .us_sel(us_sel),
    .postbyte(postbyte), .sp_in(sp_in),
    .pc(pc), .osp(osp), .y(y), .x(x), .dp(dp), .b(b), .a(a), .cc(cc),
    .mem(bus),
    .stack_busy(stack_busy), .pul_we(pul_we), .pul_sel(pul_sel),
    .pul_data(pul_data), .sp_upd(sp_upd), .sp_nx(sp_nx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // s = {psh_all, psh_cc, psh_pc, psh_go, rti_cc, rti_other, pul_go}
  task automatic set_strobes(input logic [6:0] s);
    {psh_all, psh_cc, psh_pc, psh_go, rti_cc, rti_other, pul_go} = s;
  endtask

  // Returns {is_push, mask} following the strobe priorities.
  function automatic logic [8:0] model_mask(input logic [6:0] s, input logic [7:0] pb);
    if (s[6]) return {1'b1, 8'hFF};
    if (s[5]) return {1'b1, 8'h81};
    if (s[4]) return {1'b1, 8'h80};
    if (s[3]) return {1'b1, pb};
    if (s[2]) return {1'b0, 8'h01};
    if (s[1]) return {1'b0, 8'hFE};
    if (s[0]) return {1'b0, pb};
    return 9'h000;
  endfunction

  function automatic logic [15:0] reg_value(input int i);
    case (i)
      7: return pc;
      6: return osp;
      5: return y;
      4: return x;
      3: return {8'h00, dp};
      2: return {8'h00, b};
      1: return {8'h00, a};
      default: return {8'h00, cc};
    endcase
  endfunction

  task automatic randomize_regs();
    pc = 16'($urandom); osp = 16'($urandom); y = 16'($urandom); x = 16'($urandom);
    dp = 8'($urandom); b = 8'($urandom); a = 8'($urandom); cc = 8'($urandom);
    us_sel = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_mem(input logic [15:0] base);
    logic [15:0] ad;
    logic [7:0]  v;
    for (int j = 0; j < 12; j++) begin
      ad = base + 16'(j);
      v  = 8'($urandom);
      mem_arr[ad] = v;
      ref_mem[ad] = v;
    end
  endtask

  // One operation: build the expected byte traffic, drive the strobe for a
  // single cycle, then collect bus writes, load strobes and SP updates.
  task automatic run_op(input string name, input logic [6:0] s, input logic [7:0] pb,
                        input logic [15:0] sp, input int stall_at, input int stall_len,
                        input bit rnd_stall, input bit rnd_cen, input int rst_at);
    logic [8:0]  pm;
    logic [7:0]  m;
    bit          push;
    logic [15:0] msp, v, obs_nx;
    int          nbytes, n_upd, busy_cyc, k;
    bit          done, aborted;
    logic [15:0] exp_wa[$], obs_wa[$], exp_pd[$], obs_pd[$];
    logic [7:0]  exp_wd[$], obs_wd[$];
    logic [2:0]  exp_ps[$], obs_ps[$];

    pm = model_mask(s, pb);
    push = pm[8];
    m = pm[7:0];
    msp = sp;
    nbytes = 0;
    if (push) begin
      for (int i = 7; i >= 0; i--) if (m[i]) begin
        v = reg_value(i);
        msp = msp - 16'd1; exp_wa.push_back(msp); exp_wd.push_back(v[7:0]); nbytes++;
        if (i >= 4) begin
          msp = msp - 16'd1; exp_wa.push_back(msp); exp_wd.push_back(v[15:8]); nbytes++;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) if (m[i]) begin
        if (i >= 4) begin
          v = {ref_mem[msp], ref_mem[msp + 16'd1]};
          msp = msp + 16'd2; nbytes += 2;
        end else begin
          v = {8'h00, ref_mem[msp]};
          msp = msp + 16'd1; nbytes++;
        end
        exp_ps.push_back(3'(i));
        exp_pd.push_back(v);
      end
    end
    if (rst_at >= 0) begin
      while (exp_wa.size() > rst_at) begin
        void'(exp_wa.pop_back());
        void'(exp_wd.pop_back());
      end
    end
    foreach (exp_wa[i]) ref_mem[exp_wa[i]] = exp_wd[i];

    set_strobes(s);
    postbyte = pb;
    sp_in = sp;
    k = 0; done = 0; aborted = 0; n_upd = 0; busy_cyc = 0; obs_nx = 16'h0;
    while (!done) begin
      cen = (rnd_cen && k > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.mem_busy = rnd_stall ? ($urandom_range(0, 3) == 0)
                               : (k >= stall_at && k < stall_at + stall_len);
      // Strobes arriving mid-transfer must be ignored.
      if (k == 1 && m != 8'h00) begin psh_all = 1'b1; pul_go = 1'b1; rti_cc = 1'b1; end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check({name, ".rst_we"}, 32'(bus.we), 32'd0);
        check({name, ".rst_busy"}, 32'(stack_busy), 32'd0);
        aborted = 1;
      end
      @(negedge clk);
      if (stack_busy) busy_cyc++;
      if (cen && !bus.mem_busy && bus.we) begin
        obs_wa.push_back(bus.addr);
        obs_wd.push_back(bus.dout);
        mem_arr[bus.addr] = bus.dout;
      end
      if (cen && pul_we) begin obs_ps.push_back(pul_sel); obs_pd.push_back(pul_data); end
      if (cen && sp_upd) begin n_upd++; obs_nx = sp_nx; end
      if (!rnd_stall && stall_len > 0 && k >= stall_at && k < stall_at + stall_len
          && push && stall_at < exp_wa.size()) begin
        check($sformatf("%s.hold_addr%0d", name, k), 32'(bus.addr), 32'(exp_wa[stall_at]));
        check($sformatf("%s.hold_dout%0d", name, k), 32'(bus.dout), 32'(exp_wd[stall_at]));
        check($sformatf("%s.hold_we%0d", name, k), 32'(bus.we), 32'd1);
      end
      @(posedge clk);
      #1;
      set_strobes(7'd0);
      k++;
      if (aborted) begin
        rst = 1'b0;
        done = 1;
      end else if (!stack_busy) begin
        done = 1;
      end else if (k > 400) begin
        checks++;
        failures++;
        $error("FAIL %s.timeout observed=busy_after_%0d_cycles expected=idle", name, k);
        done = 1;
      end
    end
    bus.mem_busy = 1'b0;
    cen = 1'b1;

    check({name, ".nwr"}, 32'(obs_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
      check($sformatf("%s.wa%0d", name, i), 32'(obs_wa[i]), 32'(exp_wa[i]));
      check($sformatf("%s.wd%0d", name, i), 32'(obs_wd[i]), 32'(exp_wd[i]));
    end
    check({name, ".npul"}, 32'(obs_ps.size()), 32'(aborted ? 0 : exp_ps.size()));
    for (int i = 0; i < exp_ps.size() && i < obs_ps.size(); i++) begin
      check($sformatf("%s.psel%0d", name, i), 32'(obs_ps[i]), 32'(exp_ps[i]));
      check($sformatf("%s.pdat%0d", name, i), 32'(obs_pd[i]), 32'(exp_pd[i]));
    end
    check({name, ".nupd"}, 32'(n_upd), (m != 8'h00 && !aborted) ? 32'd1 : 32'd0);
    if (m != 8'h00 && !aborted)
      check({name, ".sp_nx"}, 32'(obs_nx), 32'(msp));
    if (!rnd_stall && !rnd_cen && !aborted)
      check({name, ".busy_cycles"}, 32'(busy_cyc),
            (m != 8'h00) ? 32'(nbytes + 1 + stall_len) : 32'd0);
    $display("op %-12s push=%0d mask=%02h sp=%04h writes=%0d pulls=%0d upd=%0d busy=%0d",
             name, push, m, sp, obs_wa.size(), obs_ps.size(), n_upd, busy_cyc);
  endtask

  initial begin
    logic [6:0]  s;
    logic [7:0]  pb;
    logic [15:0] sp;
    bit          rs, rc;

    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1; cen = 1'b1; set_strobes(7'd0);
    postbyte = 8'h00; sp_in = 16'h0000; bus.mem_busy = 1'b0;
    randomize_regs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(stack_busy), 32'd0);
    check("reset.we", 32'(bus.we), 32'd0);
    check("reset.addr", 32'(bus.addr), 32'd0);
    check("reset.dout", 32'(bus.dout), 32'd0);
    check("reset.pul_we", 32'(pul_we), 32'd0);
    check("reset.pul_data", 32'(pul_data), 32'd0);
    check("reset.sp_upd", 32'(sp_upd), 32'd0);
    check("reset.sp_nx", 32'(sp_nx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full IRQ-style push from 0400
    pc = 16'h1234; cc = 8'h80;
    run_op("psh_all", 7'b1000000, 8'h00, 16'h0400, 0, 0, 0, 0, -1);

    // Pull A, B, PC from 03F0
    mem_arr[16'h03F0] = 8'h11; mem_arr[16'h03F1] = 8'h22;
    mem_arr[16'h03F2] = 8'hAB; mem_arr[16'h03F3] = 8'hCD;
    ref_mem[16'h03F0] = 8'h11; ref_mem[16'h03F1] = 8'h22;
    ref_mem[16'h03F2] = 8'hAB; ref_mem[16'h03F3] = 8'hCD;
    run_op("pul_86", 7'b0000001, 8'h86, 16'h03F0, 0, 0, 0, 0, -1);

    // FIRQ push across the 0000/FFFF wrap, psh_cc beating psh_go
    randomize_regs();
    run_op("psh_cc_wrap", 7'b0101000, 8'h00, 16'h0001, 0, 0, 0, 0, -1);

    // Memory stall on the second byte of a JSR push
    run_op("psh_pc_stall", 7'b0010000, 8'h00, 16'h2000, 1, 3, 0, 0, -1);

    // Reset during the third byte, then a clean push
    randomize_regs();
    run_op("psh_all_rst", 7'b1000000, 8'h00, 16'h0800, 0, 0, 0, 0, 2);
    run_op("psh_pc_after", 7'b0010000, 8'h00, 16'h0900, 0, 0, 0, 0, -1);

    // Empty pull mask
    run_op("pul_zero", 7'b0000001, 8'h00, 16'h0500, 0, 0, 0, 0, -1);

    // Push beats pull; rti_cc beats rti_other
    randomize_regs();
    run_op("psh_vs_pul", 7'b0001001, 8'h5A, 16'h1000, 0, 0, 0, 0, -1);
    fill_mem(16'hFFFA);
    run_op("rti_prio", 7'b0000110, 8'h00, 16'hFFFA, 0, 0, 0, 0, -1);
    fill_mem(16'hFFF8);
    run_op("rti_other", 7'b0000010, 8'h00, 16'hFFF8, 0, 0, 0, 0, -1);

    // Random operations with random stalls and clock enables
    for (int n = 0; n < 40; n++) begin
      randomize_regs();
      if ($urandom_range(0, 3) == 0) s = 7'($urandom_range(0, 127));
      else                           s = 7'd1 << $urandom_range(0, 6);
      pb = 8'($urandom);
      sp = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      fill_mem(sp);
      run_op($sformatf("rnd%0d", n), s, pb, sp, 0, 0, rs, rc, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
